// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl_if
//  Brief    : Time bus between the clock-set controller and the timekeeper.
//  Revision : 1.0
// ============================================================================
interface clock_set_ctrl_if;
    logic [6:0] hrs_i;
    logic [6:0] mins_i;
    logic [6:0] secs_i;
    logic [6:0] hrs_o;
    logic [6:0] mins_o;
    logic [6:0] secs_o;
    logic       load_o;
    logic [2:0] blank_o;
    logic       setting_o;

    modport slave (
        input  hrs_i, mins_i, secs_i,
        output hrs_o, mins_o, secs_o, load_o, blank_o, setting_o
    );

    modport master (
        output hrs_i, mins_i, secs_i,
        input  hrs_o, mins_o, secs_o, load_o, blank_o, setting_o
    );
endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Brief    : Two-button time-set controller with blinking field and load strobe.
//  Revision : 1.0
// ============================================================================
module clock_set_ctrl #(
    parameter int blink_tc_p = 24999999,
    parameter int hrs_max_p  = 23
) (
    input  logic            clk_i,
    input  logic            nRst_i,
    input  logic            nMode_i,
    input  logic            nInc_i,
    clock_set_ctrl_if.slave bus
);

    localparam int              CNT_W     = (blink_tc_p > 0) ? $clog2(blink_tc_p + 1) : 1;
    localparam logic [CNT_W-1:0] c_BLINK_TC = CNT_W'(blink_tc_p);
    localparam logic [6:0]      c_HRS_MAX = 7'(hrs_max_p);
    localparam logic [6:0]      c_MS_MAX  = 7'd59;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    // Button pipeline, bit 1 = mode, bit 0 = inc.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] prev_q;
    logic [1:0] arm_q;
    logic [1:0] press_q;
    logic [1:0] fill_q;

    state_t           state_q, state_d;
    logic [6:0]       hrs_q, hrs_d;
    logic [6:0]       mins_q, mins_d;
    logic [6:0]       secs_q, secs_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    logic w_mode_press;
    logic w_inc_press;

    assign w_mode_press = press_q[1];
    assign w_inc_press  = press_q[0];

    // A button may only fire after the synchronizer has seen it released with
    // real samples; fill_q marks when sync2_q no longer holds its reset value.
    always_ff @(posedge clk_i) begin
        if (!nRst_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
            arm_q   <= 2'b00;
            press_q <= 2'b00;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= {nMode_i, nInc_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            arm_q   <= arm_q | ({2{fill_q[1]}} & sync2_q);
            press_q <= arm_q & prev_q & ~sync2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nRst_i) begin
            state_q <= ST_RUN;
            hrs_q   <= 7'd0;
            mins_q  <= 7'd0;
            secs_q  <= 7'd0;
            load_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hrs_q   <= hrs_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hrs_d   = hrs_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;
        phase_d = phase_q;

        if (state_q != ST_RUN) begin
            if (cnt_q == c_BLINK_TC) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (w_mode_press) begin
                    state_d = ST_SET_H;
                    hrs_d   = (bus.hrs_i  > c_HRS_MAX) ? 7'd0 : bus.hrs_i;
                    mins_d  = (bus.mins_i > c_MS_MAX)  ? 7'd0 : bus.mins_i;
                    secs_d  = (bus.secs_i > c_MS_MAX)  ? 7'd0 : bus.secs_i;
                end
            end
            ST_SET_H: begin
                if (w_mode_press) begin
                    state_d = ST_SET_M;
                end else if (w_inc_press) begin
                    hrs_d = (hrs_q >= c_HRS_MAX) ? 7'd0 : hrs_q + 7'd1;
                end
            end
            ST_SET_M: begin
                if (w_mode_press) begin
                    state_d = ST_SET_S;
                end else if (w_inc_press) begin
                    mins_d = (mins_q >= c_MS_MAX) ? 7'd0 : mins_q + 7'd1;
                end
            end
            ST_SET_S: begin
                if (w_mode_press) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (w_inc_press) begin
                    secs_d = (secs_q >= c_MS_MAX) ? 7'd0 : secs_q + 7'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Restart the blink so the field is visible right after any change.
        if ((state_d != state_q) || (w_inc_press && (state_q != ST_RUN))) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    logic [2:0] w_blank;

    always_comb begin
        w_blank = 3'b000;
        case (state_q)
            ST_SET_H: w_blank[2] = phase_q;
            ST_SET_M: w_blank[1] = phase_q;
            ST_SET_S: w_blank[0] = phase_q;
            default:  w_blank    = 3'b000;
        endcase
    end

    assign bus.hrs_o     = hrs_q;
    assign bus.mins_o    = mins_q;
    assign bus.secs_o    = secs_q;
    assign bus.load_o    = load_q;
    assign bus.blank_o   = w_blank;
    assign bus.setting_o = (state_q != ST_RUN);

endmodule
`default_nettype wire
